// File: rtl/countdown_99_if.sv
// Control/status bundle for the countdown timer; clk and reset stay outside.
interface countdown_99_if;
  logic       load;
  logic [7:0] load_value;
  logic       start;
  logic       pause;
  logic       tick;
  logic [7:0] count;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       running;
  logic       done;
  logic       expired;

  modport master (
    output load, load_value, start, pause, tick,
    input  count, tens, ones, running, done, expired
  );

  modport slave (
    input  load, load_value, start, pause, tick,
    output count, tens, ones, running, done, expired
  );
endinterface

// File: rtl/countdown_99.sv
// Loadable down-counter with start/pause control, expiry pulse and BCD digits.
module countdown_99 #(
  parameter logic [7:0] MAX = 8'd99
) (
  input  logic           clk,
  input  logic           reset,
  countdown_99_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  state_t     state, state_next;
  logic [7:0] count, count_next;
  logic       done, done_next;
  logic [3:0] tens;
  logic [7:0] tens_x10;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= 8'd0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      done  <= done_next;
    end
  end

  // load dominates; within RUN, pause beats tick so a paused count never moves
  always_comb begin
    state_next = state;
    count_next = count;
    done_next  = 1'b0;
    if (bus.load) begin
      count_next = (bus.load_value > MAX) ? MAX : bus.load_value;
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, PAUSED: begin
          if (bus.start && count != 8'd0) state_next = RUN;
        end
        RUN: begin
          if (bus.pause) begin
            state_next = PAUSED;
          end else if (bus.tick) begin
            if (count > 8'd1) begin
              count_next = count - 8'd1;
            end else begin
              count_next = 8'd0;
              state_next = EXPIRED;
              done_next  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // tens found by threshold compare; counts above 99 saturate at 9 (don't-care)
  always_comb begin
    tens = 4'd0;
    for (int i = 1; i < 10; i++)
      if (count >= 8'(i * 10)) tens = 4'(i);
    tens_x10 = {4'd0, tens} * 8'd10;
  end

  assign bus.count   = count;
  assign bus.tens    = tens;
  assign bus.ones    = 4'(count - tens_x10);
  assign bus.running = (state == RUN);
  assign bus.expired = (state == EXPIRED);
  assign bus.done    = done;
endmodule

// File: doc/countdown_99.md
COUNTDOWN_99 -- requirements
Module: countdown_99

Interface
REQ-001 SHALL have parameter: MAX, default 8'd99, meaning the largest loadable count; load values above it are clamped.
REQ-002 SHALL have port: clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port: load  input  1  load strobe for load_value.
REQ-005 SHALL have port: load_value  input  8  binary start value for the countdown.
REQ-006 SHALL have port: start  input  1  start or resume strobe.
REQ-007 SHALL have port: pause  input  1  pause strobe.
REQ-008 SHALL have port: tick  input  1  one-cycle decrement enable, e.g. 1 Hz from a prescaler.
REQ-009 SHALL have port: count  output  8  registered binary count, range 0..MAX.
REQ-010 SHALL have port: tens  output  4  BCD tens digit of count.
REQ-011 SHALL have port: ones  output  4  BCD ones digit of count.
REQ-012 SHALL have port: running  output  1  high while in state RUN.
REQ-013 SHALL have port: done  output  1  registered one-cycle pulse on expiry.
REQ-014 SHALL have port: expired  output  1  level, high while in state EXPIRED.

Function
REQ-015 SHALL implement states IDLE, RUN, PAUSED and EXPIRED; running = (state==RUN) and expired = (state==EXPIRED).
REQ-016 SHALL give per-edge priority: reset > load > pause/start > tick.
REQ-017 load, in any state: count <= min(load_value, MAX) and state <= IDLE at the next edge; start, pause and tick are ignored that cycle.
REQ-018 start in IDLE or PAUSED with count != 0: state <= RUN at the next edge; no decrement in that same cycle, even if tick=1.
REQ-019 start in IDLE or PAUSED with count == 0: SHALL be ignored; state stays put and done stays 0.
REQ-020 start in RUN or EXPIRED: SHALL be ignored.
REQ-021 pause in RUN: state <= PAUSED and count holds, even if tick=1 in the same cycle.
REQ-022 pause outside RUN: SHALL be ignored; start and pause together in RUN behave as pause alone.
REQ-023 In RUN, tick with count > 1: count <= count - 1 at the next edge.
REQ-024 In RUN, tick with count == 1: at the same edge, count <= 0, state <= EXPIRED and done <= 1.
REQ-025 done SHALL be high for exactly one cycle and low otherwise.
REQ-026 tick outside RUN: SHALL be ignored, so count holds.
REQ-027 count SHALL never wrap below 0; in EXPIRED, count holds 0 until load or reset.
REQ-028 tens = count/10 and ones = count%10, combinational from count and valid for all counts 0..99; for count > 99 (only possible if MAX > 99), tens and ones are don't-care.
REQ-029 Latency: count, running, expired and done change one edge after the qualifying input is sampled; tens and ones follow count in the same cycle.

Reset
REQ-030 reset=1 at a rising edge: count <= 0, state <= IDLE, done <= 0, regardless of all other inputs.
REQ-031 Reset outputs: count=0, tens=0, ones=0, running=0, done=0, expired=0.
REQ-032 Reset mid-RUN or on the edge where expiry would occur: the IDLE/0 reset result wins and no done pulse is produced.
REQ-033 No initial blocks SHALL be relied on for reset state.

Verification
REQ-034 reset; load 42; start; 42 ticks -> count steps 42..0, tens/ones 4/2..0/0; done pulses once on the 42nd tick edge; expired=1; running=0.
REQ-035 load 150 -> count=99, tens=9, ones=9, state IDLE; load 0, then start -> stays IDLE, running=0, done never asserts.
REQ-036 load 10; start; 3 ticks (count=7); pause and tick in the same cycle -> count=7, PAUSED; 5 ticks -> count=7; start, 7 ticks -> EXPIRED, done pulse.
REQ-037 load 5; start; reset on the cycle of the 3rd tick -> count=0, IDLE, all outputs 0; load during RUN at count=3 with value 20 -> count=20, IDLE, running=0.
REQ-038 In EXPIRED: start and tick for 10 cycles -> count=0, expired=1, done=0; then load 1, start, tick -> done pulses again.
REQ-039 Sweep all loads 0..99 -> tens*10 + ones == count every cycle; start and tick together in IDLE at count=9 -> RUN next cycle with count still 9.
